// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard front end:
// scan-code constants, key-event field layout and parser state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERROR  = 8'h00;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam int EVT_W   = 10;
    localparam int BRK_BIT = 9;
    localparam int EXT_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    // Keyboard housekeeping replies that never represent a key.
    function automatic logic is_control_byte(input logic [7:0] b);
        return (b == SC_ERROR) || (b == SC_BAT_OK) || (b == SC_PAUSE) ||
               (b == SC_ECHO)  || (b == SC_ACK)    || (b == SC_RESEND);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == SC_LSHIFT) || (b == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a drop strobe;
// push and pop in the same cycle both take effect even when full.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan parser feeding a key-event FIFO, plus live arrow-key held state.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes from the FIFO.
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_key_pressed,
    input  logic [7:0]       ps2_key_data,
    output logic [9:0]       evt_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic             timeout_err,
    output logic [3:0]       arrow_held
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    parse_state_t     state;
    parse_state_t     next_state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             emit;
    logic [EVT_W-1:0] emit_evt;
    logic             is_repeat;
    logic             push_q;
    logic [EVT_W-1:0] push_evt_q;
    logic             fifo_drop;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        emit_evt   = '0;
        tmo_hit    = 1'b0;
        if (ps2_key_pressed) begin
            unique case (state)
                ST_IDLE: begin
                    if (ps2_key_data == SC_EXT) begin
                        next_state = ST_EXT;
                    end else if (ps2_key_data == SC_BRK) begin
                        next_state = ST_BRK;
                    end else if (!is_control_byte(ps2_key_data)) begin
                        emit     = 1'b1;
                        emit_evt = {2'b00, ps2_key_data};
                    end
                end
                ST_EXT: begin
                    if (ps2_key_data == SC_BRK) begin
                        next_state = ST_EXT_BRK;
                    end else if (ps2_key_data != SC_EXT) begin
                        next_state = ST_IDLE;
                        emit       = !is_fake_shift(ps2_key_data);
                        emit_evt   = {2'b01, ps2_key_data};
                    end
                end
                ST_BRK: begin
                    if (ps2_key_data != SC_BRK) begin
                        next_state = ST_IDLE;
                        emit       = 1'b1;
                        emit_evt   = {2'b10, ps2_key_data};
                    end
                end
                ST_EXT_BRK: begin
                    next_state = ST_IDLE;
                    emit       = !is_fake_shift(ps2_key_data);
                    emit_evt   = {2'b11, ps2_key_data};
                end
            endcase
        end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
            next_state = ST_IDLE;
            tmo_hit    = 1'b1;
        end
    end

    // Prefix watchdog: counts idle cycles since the last byte of an unfinished sequence.
    always_ff @(posedge clock) begin
        if (reset || ps2_key_pressed || state == ST_IDLE || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       last_make_valid;

    assign is_repeat = !emit_evt[BRK_BIT] && last_make_valid && (last_make == emit_evt[8:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_make       <= '0;
            last_make_valid <= 1'b0;
        end else if (emit) begin
            if (emit_evt[BRK_BIT]) begin
                if (last_make == emit_evt[8:0]) last_make_valid <= 1'b0;
            end else if (!is_repeat) begin
                last_make       <= emit_evt[8:0];
                last_make_valid <= 1'b1;
            end
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            push_q      <= 1'b0;
            push_evt_q  <= '0;
            timeout_err <= 1'b0;
        end else begin
            push_q      <= emit && !is_repeat;
            push_evt_q  <= emit_evt;
            timeout_err <= tmo_hit;
        end
    end

    // Arrow state follows every parsed event, whether or not the FIFO keeps it.
    always_ff @(posedge clock) begin
        if (reset) begin
            arrow_held <= '0;
        end else if (emit && emit_evt[EXT_BIT]) begin
            case (emit_evt[7:0])
                SC_UP:    arrow_held[0] <= !emit_evt[BRK_BIT];
                SC_DOWN:  arrow_held[1] <= !emit_evt[BRK_BIT];
                SC_LEFT:  arrow_held[2] <= !emit_evt[BRK_BIT];
                SC_RIGHT: arrow_held[3] <= !emit_evt[BRK_BIT];
                default:  arrow_held <= arrow_held;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)          overflow <= 1'b0;
        else if (fifo_drop) overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_q),
        .push_data  (push_evt_q),
        .pop        (evt_ready),
        .head_data  (evt_data),
        .head_valid (evt_valid),
        .count      (fifo_count),
        .drop       (fifo_drop)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: a flag-based byte parser and a queue
// FIFO model predict events; a negedge monitor compares every pop and status output.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       ovf_clear;
    logic       timeout_err;
    logic [3:0] arrow_held;

    ps2_key_event_queue #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .evt_data        (evt_data),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .ovf_clear       (ovf_clear),
        .timeout_err     (timeout_err),
        .arrow_held      (arrow_held)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int tmo_seen = 0;
    bit chk_en   = 0;
    bit rand_ready = 0;

    logic [9:0] exp_q[$];

    bit         m_ext = 0, m_brk = 0;
    int         m_gap = 0;
    int         m_count = 0;
    bit         m_ovf = 0, m_tmo = 0;
    logic [3:0] m_arrow = '0;
    bit         m_pend_v = 0;
    logic [9:0] m_pend = '0;
    bit         lm_v = 0;
    logic [8:0] lm = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A complete key event: update arrows, apply repeat filter, schedule the push.
    task automatic model_event(input logic [9:0] e, output bit keep);
        keep = 1;
        if (e[8]) begin
            if (e[7:0] == 8'h75) m_arrow[0] = !e[9];
            if (e[7:0] == 8'h72) m_arrow[1] = !e[9];
            if (e[7:0] == 8'h6B) m_arrow[2] = !e[9];
            if (e[7:0] == 8'h74) m_arrow[3] = !e[9];
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!e[9]) begin
            if (lm_v && lm == e[8:0]) keep = 0;
            else begin lm = e[8:0]; lm_v = 1; end
        end else if (lm_v && lm == e[8:0]) begin
            lm_v = 0;
        end
`endif
    endtask

    task automatic model_byte(input logic [7:0] b, output bit nv, output logic [9:0] ne);
        bit done;
        bit fake;
        bit ctrl;
        fake = (b == 8'h12) || (b == 8'h59);
        ctrl = (b == 8'h00) || (b == 8'hAA) || (b == 8'hE1) || (b == 8'hEE) || (b == 8'hFA) || (b == 8'hFE);
        done = 0; nv = 0; ne = '0;
        if (!m_ext && !m_brk) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (!ctrl) begin done = 1; ne = {2'b00, b}; end
        end else if (m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                m_ext = 0;
                if (!fake) begin done = 1; ne = {2'b01, b}; end
            end
        end else if (!m_ext) begin
            if (b != 8'hF0) begin m_brk = 0; done = 1; ne = {2'b10, b}; end
        end else begin
            m_ext = 0; m_brk = 0;
            if (!fake) begin done = 1; ne = {2'b11, b}; end
        end
        if (done) model_event(ne, nv);
    endtask

    task automatic model_step();
        bit pop, drop, nv;
        logic [9:0] ne;
        nv = 0; ne = '0; drop = 0;
        if (reset) begin
            m_ext = 0; m_brk = 0; m_gap = 0; m_count = 0; m_ovf = 0; m_tmo = 0;
            m_arrow = '0; m_pend_v = 0; lm_v = 0;
            exp_q.delete();
        end else begin
            pop = evt_ready && (m_count > 0);
            if (m_pend_v) begin
                if (m_count < DEPTH || pop) begin exp_q.push_back(m_pend); m_count++; end
                else drop = 1;
            end
            if (pop) m_count--;
            if (drop) m_ovf = 1;
            else if (ovf_clear) m_ovf = 0;
            m_tmo = 0;
            if (ps2_key_pressed) begin
                m_gap = 0;
                model_byte(ps2_key_data, nv, ne);
            end else if (m_ext || m_brk) begin
                m_gap++;
                if (m_gap == TMO) begin m_ext = 0; m_brk = 0; m_gap = 0; m_tmo = 1; end
            end
            m_pend_v = nv;
            m_pend   = ne;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            checkOutput("fifo_count", fifo_count, m_count);
            checkOutput("evt_valid", evt_valid, m_count != 0);
            checkOutput("overflow", overflow, m_ovf);
            checkOutput("timeout_err", timeout_err, m_tmo);
            checkOutput("arrow_held", arrow_held, m_arrow);
            if (timeout_err) tmo_seen++;
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL evt_pop: got 0x%0h, expected no event at %0t", evt_data, $time);
                end else begin
                    checkOutput("evt_data", evt_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) evt_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        tick();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'($urandom);
        repeat (gap) tick();
    endtask

    initial begin
        int tmo_before;
        logic [7:0] b;
        int gap;
        logic [7:0] typ [6];
        typ[0] = 8'h1C; typ[1] = 8'h1C; typ[2] = 8'h1C;
        typ[3] = 8'hF0; typ[4] = 8'h1C; typ[5] = 8'h1C;

        reset = 1'b1; ps2_key_pressed = 1'b0; ps2_key_data = '0;
        evt_ready = 1'b0; ovf_clear = 1'b0;
        repeat (2) tick();
        chk_en = 1;
        checkOutput("reset_evt_valid", evt_valid, 0);
        checkOutput("reset_evt_data", evt_data, 0);
        checkOutput("reset_fifo_count", fifo_count, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_arrow_held", arrow_held, 0);
        reset = 1'b0;
        tick();

        applyStimulus(8'h1C, 3);
        checkOutput("single_head", evt_data, 10'h01C);
        checkOutput("single_count", fifo_count, 1);
        evt_ready = 1'b1;
        repeat (2) tick();

        applyStimulus(8'hE0, 1);
        applyStimulus(8'h75, 2);
        checkOutput("arrow_up_held", arrow_held, 4'b0001);
        applyStimulus(8'hE0, 1);
        applyStimulus(8'hF0, 1);
        applyStimulus(8'h75, 2);
        checkOutput("arrow_up_released", arrow_held, 4'b0000);

        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(8'h15 + 8'(i), 1);
        repeat (2) tick();
        checkOutput("full_count", fifo_count, DEPTH);
        checkOutput("full_overflow", overflow, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);

        ps2_key_pressed = 1'b1; ps2_key_data = 8'h2C;
        tick();
        ps2_key_pressed = 1'b0;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick();
        checkOutput("full_pushpop_count", fifo_count, DEPTH);
        checkOutput("full_pushpop_ovf", overflow, 0);
        evt_ready = 1'b1;
        repeat (DEPTH + 2) tick();

        tmo_before = tmo_seen;
        applyStimulus(8'hF0, TMO + 3);
        checkOutput("timeout_pulses", tmo_seen - tmo_before, 1);
        applyStimulus(8'h1C, 3);
        applyStimulus(8'hF0, TMO - 1);
        applyStimulus(8'h1C, 3);
        applyStimulus(8'hE0, TMO);
        applyStimulus(8'h74, 3);

        applyStimulus(8'hE0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(8'h74, 3);
        checkOutput("reset_mid_seq_arrow", arrow_held, 4'b0000);

        for (int i = 0; i < 6; i++) applyStimulus(typ[i], 2);
        repeat (3) tick();

        rand_ready = 1;
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 11))
                0: b = 8'hE0;  1: b = 8'hF0;  2: b = 8'h12;  3: b = 8'h59;
                4: b = 8'h75;  5: b = 8'h72;  6: b = 8'h6B;  7: b = 8'h74;
                8: b = 8'h1C;  9: b = 8'hAA; 10: b = 8'hE1;
                default: b = 8'($urandom);
            endcase
            gap = ($urandom_range(0, 9) == 0) ? (TMO - 1 + int'($urandom_range(0, 2))) : int'($urandom_range(0, 3));
            ovf_clear = ($urandom_range(0, 15) == 0);
            applyStimulus(b, gap);
        end
        ovf_clear = 1'b0;
        rand_ready = 0;
        evt_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
